// File: rtl/multi_clean_pulse.sv
// Multi-channel push-button cleaner: per channel a 2-flop synchroniser feeding a Moore FSM
// that emits one-cycle press/release pulses and locks out bounce for DEBOUNCE cycles each way.
module multi_clean_pulse #(
  parameter int CHANNELS  = 4,
  parameter int DEBOUNCE  = 50000,
  parameter int CNT_WIDTH = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw,
  input  logic                en,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] busy,
  output logic                any_press
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRESSED  = 3'd1,
    S_ON       = 3'd2,
    S_WAITING  = 3'd3,
    S_RELEASED = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE - 1);

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] raw_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      raw_s <= '0;
    end else begin
      sync1 <= raw;
      raw_s <= sync1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 delay;

    assign delay = (cnt == CNT_LAST);

    always_ff @(posedge clock) begin
      if (reset) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        state <= state_next;
        cnt   <= cnt_next;
      end
    end

    // The counter only runs during the two lockout windows and stops at CNT_LAST.
    always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
        S_IDLE: begin
          cnt_next = '0;
          if (raw_s[i] && en) state_next = S_PRESSED;
        end
        S_PRESSED: begin
          state_next = S_ON;
          cnt_next   = delay ? '0 : cnt + CNT_WIDTH'(1);
        end
        S_ON: begin
          if (delay) begin
            state_next = S_WAITING;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_WIDTH'(1);
          end
        end
        S_WAITING: begin
          cnt_next = '0;
          if (!raw_s[i]) state_next = S_RELEASED;
        end
        S_RELEASED: begin
          if (delay) begin
            state_next = S_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    assign press_pulse[i]   = (state == S_PRESSED);
    assign release_pulse[i] = (state == S_RELEASED) && (cnt == '0);
    assign level[i]         = (state == S_PRESSED) || (state == S_ON) || (state == S_WAITING);
    assign busy[i]          = (state != S_IDLE);
  end

  assign any_press = |press_pulse;

endmodule

// File: tb/tb_multi_clean_pulse.sv
// Scoreboard bench for multi_clean_pulse (CHANNELS=4, DEBOUNCE=4): stimulus queues the
// hand-computed cycle of every press/release pulse, a negedge monitor checks each cycle.
module tb_multi_clean_pulse;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] raw;
  logic       en;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] level;
  logic [3:0] busy;
  logic       any_press;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
  } ev_t;

  ev_t exp_q[$];

  multi_clean_pulse #(
    .CHANNELS (4),
    .DEBOUNCE (4),
    .CNT_WIDTH(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .raw          (raw),
    .en           (en),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .level        (level),
    .busy         (busy),
    .any_press    (any_press)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  function automatic void add_exp(input int c, input logic [3:0] p, input logic [3:0] r);
    ev_t e;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc == c) begin
        exp_q[i].press |= p;
        exp_q[i].rel   |= r;
        return;
      end
    end
    e.cyc = c;
    e.press = p;
    e.rel = r;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc > c) begin
        exp_q.insert(i, e);
        return;
      end
    end
    exp_q.push_back(e);
  endfunction

  // Monitor: pulses must appear exactly in the queued cycles and nowhere else.
  always @(negedge clock) begin
    logic [3:0] ep;
    logic [3:0] er;
    ep = 4'h0;
    er = 4'h0;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      ep = exp_q[0].press;
      er = exp_q[0].rel;
      void'(exp_q.pop_front());
    end
    chk("press_pulse", 32'(press_pulse), 32'(ep));
    chk("release_pulse", 32'(release_pulse), 32'(er));
    chk("any_press", 32'(any_press), 32'(ep != 4'h0));
  end

  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    reset = 1'b1;
    raw   = 4'h0;
    en    = 1'b0;
    step_to(3);
    chk("reset_level", 32'(level), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    step_to(5);

    // Single press held 20 cycles on channel 0
    t0 = cyc;
    raw = 4'b0001;
    en  = 1'b1;
    add_exp(t0 + 3, 4'b0001, 4'b0000);
    step_to(t0 + 4);
    chk("t1_level_on", 32'(level), 32'b0001);
    chk("t1_busy_on", 32'(busy), 32'b0001);
    step_to(t0 + 20);
    chk("t1_level_wait", 32'(level), 32'b0001);
    raw = 4'b0000;
    add_exp(t0 + 23, 4'b0000, 4'b0001);
    step_to(t0 + 28);
    chk("t1_level_idle", 32'(level), 32'h0);
    chk("t1_busy_idle", 32'(busy), 32'h0);

    // Bounce on channel 1 right after the press
    t0 = cyc;
    raw = 4'b0010;
    add_exp(t0 + 3, 4'b0010, 4'b0000);
    step_to(t0 + 1); raw = 4'b0000;
    step_to(t0 + 2); raw = 4'b0010;
    step_to(t0 + 3); raw = 4'b0000;
    step_to(t0 + 4); raw = 4'b0010;
    step_to(t0 + 15);
    chk("t2_level_held", 32'(level), 32'b0010);
    raw = 4'b0000;
    add_exp(t0 + 18, 4'b0000, 4'b0010);
    step_to(t0 + 24);
    chk("t2_busy_idle", 32'(busy), 32'h0);

    // Short press on channel 2 released before ON ends
    t0 = cyc;
    raw = 4'b0100;
    add_exp(t0 + 3, 4'b0100, 4'b0000);
    step_to(t0 + 2);
    raw = 4'b0000;
    add_exp(t0 + 8, 4'b0000, 4'b0100);
    step_to(t0 + 4);
    chk("t3_level_on", 32'(level), 32'b0100);
    step_to(t0 + 7);
    chk("t3_level_waiting", 32'(level), 32'b0100);
    chk("t3_busy_waiting", 32'(busy), 32'b0100);
    step_to(t0 + 8);
    chk("t3_level_released", 32'(level), 32'h0);
    chk("t3_busy_released", 32'(busy), 32'b0100);
    step_to(t0 + 11);
    chk("t3_busy_last_lockout", 32'(busy), 32'b0100);
    step_to(t0 + 12);
    chk("t3_busy_idle", 32'(busy), 32'h0);

    // All four channels pressed together
    t0 = cyc;
    raw = 4'b1111;
    add_exp(t0 + 3, 4'b1111, 4'b0000);
    step_to(t0 + 2);
    raw = 4'b0000;
    add_exp(t0 + 8, 4'b0000, 4'b1111);
    step_to(t0 + 4);
    chk("t4_level_all", 32'(level), 32'b1111);
    step_to(t0 + 13);
    chk("t4_busy_idle", 32'(busy), 32'h0);

    // en gating on channel 3
    t0 = cyc;
    en  = 1'b0;
    raw = 4'b1000;
    step_to(t0 + 6);
    chk("t5_level_blocked", 32'(level), 32'h0);
    chk("t5_busy_blocked", 32'(busy), 32'h0);
    en = 1'b1;
    add_exp(t0 + 7, 4'b1000, 4'b0000);
    step_to(t0 + 8);
    en = 1'b0;
    chk("t5_level_on", 32'(level), 32'b1000);
    step_to(t0 + 10);
    raw = 4'b0000;
    add_exp(t0 + 13, 4'b0000, 4'b1000);
    step_to(t0 + 17);
    chk("t5_busy_idle", 32'(busy), 32'h0);
    en = 1'b1;

    // Reset in the middle of ON on channel 0 with raw still held
    t0 = cyc;
    raw = 4'b0001;
    add_exp(t0 + 3, 4'b0001, 4'b0000);
    step_to(t0 + 4);
    chk("t6_level_on", 32'(level), 32'b0001);
    reset = 1'b1;
    step_to(t0 + 5);
    chk("t6_level_reset", 32'(level), 32'h0);
    chk("t6_busy_reset", 32'(busy), 32'h0);
    step_to(t0 + 6);
    reset = 1'b0;
    add_exp(t0 + 9, 4'b0001, 4'b0000);
    step_to(t0 + 7);
    chk("t6_level_after_reset", 32'(level), 32'h0);
    chk("t6_busy_after_reset", 32'(busy), 32'h0);
    step_to(t0 + 12);
    raw = 4'b0000;
    add_exp(t0 + 15, 4'b0000, 4'b0001);
    step_to(t0 + 20);
    chk("t6_busy_idle", 32'(busy), 32'h0);

    step_to(cyc + 3);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_clean_pulse.md
MULTI_CLEAN_PULSE -- requirements
Module: multi_clean_pulse

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent push-button channels (1..32).
REQ-002 Parameter DEBOUNCE, default 50000: lockout length in clock cycles after press and after release (minimum 2).
REQ-003 Parameter CNT_WIDTH, default 16: per-channel counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE-1.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 raw  input  CHANNELS  asynchronous raw switch levels, bit i = channel i, high = pressed.
REQ-007 en  input  1  global arm; low blocks new presses from being accepted.
REQ-008 press_pulse  output  CHANNELS  one-cycle pulse per accepted press.
REQ-009 release_pulse  output  CHANNELS  one-cycle pulse per accepted release.
REQ-010 level  output  CHANNELS  debounced button level.
REQ-011 busy  output  CHANNELS  channel not in IDLE.
REQ-012 any_press  output  1  OR of all press_pulse bits.

Function
REQ-013 Each raw bit SHALL pass through its own 2-flop synchroniser; the second-stage output (raw_s) is the only raw value the FSM uses.
REQ-014 Each channel SHALL have an independent Moore FSM: IDLE, PRESSED, ON, WAITING, RELEASED; all outputs decoded from registered state and counter only.
REQ-015 Transitions: IDLE->PRESSED if raw_s and en; PRESSED->ON unconditionally; ON->WAITING when delay; WAITING->RELEASED when !raw_s; RELEASED->IDLE when delay; unused encodings->IDLE.
REQ-016 Per-channel counter: held at 0 in IDLE and WAITING; increments by 1 each cycle in PRESSED, ON, RELEASED; cleared to 0 on the cycle delay is true; never wraps.
REQ-017 delay = (counter == DEBOUNCE-1); PRESSED+ON therefore last exactly DEBOUNCE cycles, and RELEASED exactly DEBOUNCE cycles.
REQ-018 press_pulse[i] = (state == PRESSED); exactly one cycle per accepted press.
REQ-019 release_pulse[i] = (state == RELEASED and counter == 0); exactly one cycle per accepted release.
REQ-020 level[i] high in PRESSED, ON, WAITING; low in IDLE and RELEASED.
REQ-021 Latency: raw high sampled at edge n -> PRESSED entered at edge n+2 -> press_pulse visible in the cycle after edge n+2; release symmetric.
REQ-022 raw_s changes during ON or RELEASED SHALL be ignored (bounce rejection); a press still held at end of RELEASED is re-accepted from IDLE on the next cycle if en is high.
REQ-023 en low SHALL only gate IDLE->PRESSED; channels past IDLE complete their sequence normally.
REQ-024 Channels SHALL be fully independent; simultaneous presses on several channels each produce their own pulse in the same cycle; any_press = |press_pulse.
REQ-025 If raw is released before ON ends, the FSM SHALL still enter WAITING, then RELEASED on the next cycle (release_pulse one cycle after WAITING entry).

Reset
REQ-026 With reset high at a rising edge, all FSMs SHALL go to IDLE, all counters and synchroniser flops to 0, from any state, including mid-ON or mid-RELEASED.
REQ-027 Outputs during and the cycle after reset: press_pulse=0, release_pulse=0, level=0, busy=0, any_press=0.
REQ-028 A raw input held high through reset SHALL produce a press within 3 cycles of reset deassertion (after synchroniser refill) if en is high.

Verification (DEBOUNCE=4, CHANNELS=4)
REQ-029 raw[0] 0->1 held 20 cycles, en=1 -> press_pulse[0] one cycle at t+3; level[0] high; busy[0] high; any_press one cycle.
REQ-030 raw[1] bounces 1,0,1,0,1 within 3 cycles after press then held -> exactly one press_pulse[1]; no release_pulse[1] until raw[1] drops after ON.
REQ-031 raw[2] pressed 2 cycles then released -> press_pulse, ON for 3 cycles, WAITING 1 cycle, release_pulse, RELEASED 4 cycles, IDLE; level low from RELEASED entry.
REQ-032 raw=4'b1111 same cycle -> press_pulse=4'b1111 in one cycle, any_press single pulse.
REQ-033 en=0 with raw[3] high -> no press_pulse[3]; en raised -> press_pulse[3] one cycle later; en dropped mid-ON -> sequence completes.
REQ-034 reset asserted mid-ON on channel 0 -> next cycle all outputs 0, busy=0; raw[0] still high -> fresh press_pulse[0] 3 cycles after reset release.
